// File: rtl/sort_controller.sv
// Control FSM for an in-place exchange sort over an 8-entry RAM datapath.
// Drives the RAM, operand-register and i/j counter controls from decoded state.
module sort_controller #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic Start,
  input  logic LoadWr,
  input  logic RdReq,
  input  logic AgtB,
  input  logic zi,
  input  logic zj,
  output logic EA,
  output logic EB,
  output logic WR,
  output logic Li,
  output logic Lj,
  output logic Ei,
  output logic Ej,
  output logic Csel,
  output logic Bout,
  output logic s,
  output logic Rd,
  output logic Busy,
  output logic Done
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CMP,
    WR_J,
    WR_I,
    RELOAD_A,
    NEXT_J,
    NEXT_I,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // NOTE: the state register uses non-blocking assignments and an async reset;
  // every other signal in this block is combinational decode of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output and state_next gets a default first so that no path
  // through the case statement can infer a latch.
  always_comb begin
    state_next = state;
    EA   = 1'b0;
    EB   = 1'b0;
    WR   = 1'b0;
    Li   = 1'b0;
    Lj   = 1'b0;
    Ei   = 1'b0;
    Ej   = 1'b0;
    Csel = 1'b0;
    Bout = 1'b0;
    s    = 1'b0;
    Rd   = 1'b0;
    Busy = 1'b1;
    Done = 1'b0;

    case (state)
      IDLE: begin
        Busy = 1'b0;
        Li   = 1'b1;
        WR   = LoadWr;
        Rd   = RdReq;
        if (Start) state_next = LOAD_A;
      end
      LOAD_A: begin
        s          = 1'b1;
        EA         = 1'b1;
        Lj         = 1'b1;
        state_next = LOAD_B;
      end
      LOAD_B: begin
        s          = 1'b1;
        Csel       = 1'b1;
        EB         = 1'b1;
        state_next = CMP;
      end
      CMP: begin
        s          = 1'b1;
        // Strict greater-than keeps equal keys in place.
        state_next = AgtB ? WR_J : NEXT_J;
      end
      WR_J: begin
        s          = 1'b1;
        Csel       = 1'b1;
        WR         = 1'b1;
        state_next = WR_I;
      end
      WR_I: begin
        s          = 1'b1;
        Bout       = 1'b1;
        WR         = 1'b1;
        state_next = RELOAD_A;
      end
      RELOAD_A: begin
        // A must hold the new, smaller value at address i after the swap.
        s          = 1'b1;
        EA         = 1'b1;
        state_next = NEXT_J;
      end
      NEXT_J: begin
        s = 1'b1;
        if (zj) begin
          state_next = NEXT_I;
        end else begin
          Ej         = 1'b1;
          state_next = LOAD_B;
        end
      end
      NEXT_I: begin
        s = 1'b1;
        if (zi) begin
          state_next = DONE;
        end else begin
          Ei         = 1'b1;
          state_next = LOAD_A;
        end
      end
      DONE: begin
        Busy = 1'b0;
        Done = 1'b1;
        Rd   = RdReq;
        // Waiting for Start to drop prevents a held request from re-sorting.
        if (!Start) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // External strobes pass through only while reset is released.
    if (!rst) begin
      WR = 1'b0;
      Rd = 1'b0;
    end
  end

endmodule

// File: tb/tb_sort_controller.sv
// Directed bench: sort_controller driving a behavioural 8x8 RAM datapath.
module tb_sort_controller;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  logic Start, LoadWr, RdReq;
  logic AgtB, zi, zj;
  logic EA, EB, WR, Li, Lj, Ei, Ej, Csel, Bout, s, Rd, Busy, Done;

  int compared   = 0;
  int mismatched = 0;

  sort_controller #(.N(N)) dut (
    .clk(clk), .rst(rst), .Start(Start), .LoadWr(LoadWr), .RdReq(RdReq),
    .AgtB(AgtB), .zi(zi), .zj(zj),
    .EA(EA), .EB(EB), .WR(WR), .Li(Li), .Lj(Lj), .Ei(Ei), .Ej(Ej),
    .Csel(Csel), .Bout(Bout), .s(s), .Rd(Rd), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  // Datapath: combinational RAM read, RAM write on the clock edge.
  logic [N-1:0] ram [8];
  logic [2:0]   i_q, j_q;
  logic [N-1:0] a_q, b_q;
  logic         preload;
  logic [63:0]  preload_vec;
  logic [2:0]   addr;

  assign addr = Csel ? j_q : i_q;
  assign AgtB = (a_q > b_q);
  assign zi   = (i_q == 3'd6);
  assign zj   = (j_q == 3'd7);

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 8; k++) ram[k] <= preload_vec[8*k +: 8];
      i_q <= 3'd0;
      j_q <= 3'd0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (Li)      i_q <= 3'd0;
      else if (Ei) i_q <= i_q + 3'd1;
      if (Lj)      j_q <= i_q + 3'd1;
      else if (Ej) j_q <= j_q + 3'd1;
      if (EA && s) a_q <= ram[addr];
      if (EB && s) b_q <= ram[addr];
      if (WR && s) ram[addr] <= Bout ? b_q : a_q;
    end
  end

  function automatic logic [63:0] ram_vec();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = ram[k];
    return v;
  endfunction

  task automatic load_ram(input logic [63:0] v);
    @(negedge clk);
    preload_vec = v;
    preload     = 1'b1;
    @(negedge clk);
    preload     = 1'b0;
  endtask

  // Measures one sort; comparisons are made by the calling test.
  task automatic run_sort(input bit hold_start, input bit toggle_ext,
                          output int latency, output int wrj, output int wr_busy,
                          output int cmp_cnt, output int rd_busy,
                          output int wrj_i, output int wrj_j, output bit timeout);
    bit started;
    started = 1'b0;
    latency = 0; wrj = 0; wr_busy = 0; cmp_cnt = 0; rd_busy = 0;
    wrj_i = -1; wrj_j = -1; timeout = 1'b1;
    @(negedge clk);
    Start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!started && EA && Lj) started = 1'b1;
      else if (started)         latency++;
      if (started) begin
        if (Busy && WR) wr_busy++;
        if (Busy && WR && Csel) begin
          if (wrj == 0) begin wrj_i = int'(i_q); wrj_j = int'(j_q); end
          wrj++;
        end
        if (EB) cmp_cnt++;
        if (Busy && Rd) rd_busy++;
      end
      if (Done) begin timeout = 1'b0; break; end
      if (!hold_start) Start = 1'b0;
      if (toggle_ext) begin
        LoadWr = c[0];
        RdReq  = c[1];
      end
    end
    LoadWr = 1'b0;
    RdReq  = 1'b0;
  endtask

  int  lat, wrj, wrb, cmpc, rdb, wi, wj;
  bit  tmo;

  task automatic test_reset();
    rst = 1'b0; Start = 1'b0; LoadWr = 1'b1; RdReq = 1'b1; preload = 1'b0;
    preload_vec = '0;
    @(negedge clk);
    compared++;
    if ({EA, EB, WR, Li, Lj, Ei, Ej, Csel, Bout, s, Rd, Busy, Done} !== 13'b0001000000000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 0001000000000",
               {EA, EB, WR, Li, Lj, Ei, Ej, Csel, Bout, s, Rd, Busy, Done});
    end
    rst = 1'b1;
    #1;
    compared++;
    if (WR !== 1'b1 || Rd !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_passthrough: WR=%b Rd=%b want 1 1", WR, Rd);
    end
    LoadWr = 1'b0; RdReq = 1'b0;
    #1;
    compared++;
    if (WR !== 1'b0 || Rd !== 1'b0 || Li !== 1'b1 || Busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_quiet: WR=%b Rd=%b Li=%b Busy=%b want 0 0 1 0", WR, Rd, Li, Busy);
    end
  endtask

  task automatic test_sorted();
    load_ram(64'h0706050403020100);
    run_sort(1'b0, 1'b0, lat, wrj, wrb, cmpc, rdb, wi, wj, tmo);
    compared++;
    if (tmo !== 1'b0) begin mismatched++; $display("FAIL sorted_timeout: Done never seen"); end
    compared++;
    if (lat !== 98) begin mismatched++; $display("FAIL sorted_latency: got %0d want 98", lat); end
    compared++;
    if (wrb !== 0) begin mismatched++; $display("FAIL sorted_writes: got %0d want 0", wrb); end
    compared++;
    if (cmpc !== 28) begin mismatched++; $display("FAIL sorted_compares: got %0d want 28", cmpc); end
    compared++;
    if (ram_vec() !== 64'h0706050403020100) begin
      mismatched++;
      $display("FAIL sorted_ram: got %h want 0706050403020100", ram_vec());
    end
    @(negedge clk);
    compared++;
    if (Li !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
      mismatched++;
      $display("FAIL sorted_back_idle: Li=%b Busy=%b Done=%b want 1 0 0", Li, Busy, Done);
    end
  endtask

  task automatic test_one_swap();
    load_ram(64'h0706050403020001);
    run_sort(1'b0, 1'b0, lat, wrj, wrb, cmpc, rdb, wi, wj, tmo);
    compared++;
    if (tmo !== 1'b0 || lat !== 101) begin
      mismatched++;
      $display("FAIL one_swap_latency: got %0d (timeout=%0b) want 101", lat, tmo);
    end
    compared++;
    if (wrj !== 1 || wrb !== 2) begin
      mismatched++;
      $display("FAIL one_swap_pairs: wr_j=%0d writes=%0d want 1 2", wrj, wrb);
    end
    compared++;
    if (wi !== 0 || wj !== 1) begin
      mismatched++;
      $display("FAIL one_swap_where: i=%0d j=%0d want 0 1", wi, wj);
    end
    compared++;
    if (ram_vec() !== 64'h0706050403020100) begin
      mismatched++;
      $display("FAIL one_swap_ram: got %h want 0706050403020100", ram_vec());
    end
    @(negedge clk);
  endtask

  task automatic test_reversed();
    load_ram(64'h0001020304050607);
    run_sort(1'b0, 1'b0, lat, wrj, wrb, cmpc, rdb, wi, wj, tmo);
    compared++;
    if (ram_vec() !== 64'h0706050403020100) begin
      mismatched++;
      $display("FAIL reversed_ram: got %h want 0706050403020100", ram_vec());
    end
    compared++;
    if (cmpc !== 28) begin mismatched++; $display("FAIL reversed_compares: got %0d want 28", cmpc); end
    compared++;
    if (wrj !== 28) begin mismatched++; $display("FAIL reversed_swaps: got %0d want 28", wrj); end
    compared++;
    if (tmo !== 1'b0 || lat !== 182) begin
      mismatched++;
      $display("FAIL reversed_latency: got %0d (timeout=%0b) want 182", lat, tmo);
    end
    compared++;
    if (lat !== 98 + 3 * wrj) begin
      mismatched++;
      $display("FAIL reversed_latency_rule: got %0d want %0d", lat, 98 + 3 * wrj);
    end
    @(negedge clk);
  endtask

  task automatic test_ext_ignored();
    load_ram(64'h0706050403020001);
    run_sort(1'b0, 1'b1, lat, wrj, wrb, cmpc, rdb, wi, wj, tmo);
    compared++;
    if (wrb !== 2) begin mismatched++; $display("FAIL busy_wr_count: got %0d want 2", wrb); end
    compared++;
    if (rdb !== 0) begin mismatched++; $display("FAIL busy_rd_count: got %0d want 0", rdb); end
    compared++;
    if (tmo !== 1'b0 || ram_vec() !== 64'h0706050403020100) begin
      mismatched++;
      $display("FAIL busy_ext_ram: got %h want 0706050403020100", ram_vec());
    end
    @(negedge clk);
    RdReq = 1'b1;
    #1;
    compared++;
    if (Rd !== 1'b1 || Busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_rd_follow: Rd=%b Busy=%b want 1 0", Rd, Busy);
    end
    RdReq = 1'b0; LoadWr = 1'b1;
    #1;
    compared++;
    if (Rd !== 1'b0 || WR !== 1'b1) begin
      mismatched++;
      $display("FAIL idle_wr_follow: Rd=%b WR=%b want 0 1", Rd, WR);
    end
    LoadWr = 1'b0;
  endtask

  task automatic test_start_held();
    load_ram(64'h0706050403020100);
    run_sort(1'b1, 1'b0, lat, wrj, wrb, cmpc, rdb, wi, wj, tmo);
    compared++;
    if (tmo !== 1'b0 || lat !== 98) begin
      mismatched++;
      $display("FAIL held_latency: got %0d (timeout=%0b) want 98", lat, tmo);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (Done !== 1'b1 || Busy !== 1'b0 || EA !== 1'b0) begin
      mismatched++;
      $display("FAIL held_stays_done: Done=%b Busy=%b EA=%b want 1 0 0", Done, Busy, EA);
    end
    RdReq = 1'b1; LoadWr = 1'b1;
    #1;
    compared++;
    if (Rd !== 1'b1 || WR !== 1'b0) begin
      mismatched++;
      $display("FAIL done_passthrough: Rd=%b WR=%b want 1 0", Rd, WR);
    end
    RdReq = 1'b0; LoadWr = 1'b0;
    Start = 1'b0;
    @(negedge clk);
    compared++;
    if (Li !== 1'b1 || Done !== 1'b0 || Busy !== 1'b0) begin
      mismatched++;
      $display("FAIL held_release_idle: Li=%b Done=%b Busy=%b want 1 0 0", Li, Done, Busy);
    end
    repeat (4) @(negedge clk);
    compared++;
    if (Busy !== 1'b0 || Li !== 1'b1) begin
      mismatched++;
      $display("FAIL held_no_restart: Busy=%b Li=%b want 0 1", Busy, Li);
    end
  endtask

  task automatic test_reset_mid_sort();
    bit found;
    found = 1'b0;
    load_ram(64'h0706050403020001);
    @(negedge clk);
    Start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      Start = 1'b0;
      if (Busy && WR && Csel) begin found = 1'b1; break; end
    end
    compared++;
    if (found !== 1'b1) begin mismatched++; $display("FAIL midreset_reach_wr_j: WR_J not seen"); end
    rst = 1'b0;
    #1;
    compared++;
    if (WR !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Li !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_outputs: WR=%b Busy=%b Done=%b Li=%b want 0 0 0 1", WR, Busy, Done, Li);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (ram_vec() !== 64'h0706050403020001) begin
      mismatched++;
      $display("FAIL midreset_ram_kept: got %h want 0706050403020001", ram_vec());
    end
    @(negedge clk);
    compared++;
    if (Busy !== 1'b0 || Li !== 1'b1 || WR !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_stay_idle: Busy=%b Li=%b WR=%b want 0 1 0", Busy, Li, WR);
    end
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_one_swap();
    test_reversed();
    test_ext_ignored();
    test_start_held();
    test_reset_mid_sort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
